// File: rtl/clk_div_pkg.sv
// Shared defaults and the half-period helper for the clock-enable divider bank.
// Combinational only; no state, no handshakes.
package clk_div_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_DIV_W = 8;
  // Widest divide field the helper supports; narrower fields are zero-extended into it.
  localparam int MAX_DIV_W = 32;

  // High-phase length ceil(P/2) for P = div+1, kept one bit wider so div = all-ones cannot overflow.
  function automatic logic [MAX_DIV_W:0] half(input logic [MAX_DIV_W-1:0] div);
    logic [MAX_DIV_W:0] sum;
    sum = {1'b0, div} + (MAX_DIV_W+1)'(2);
    return sum >> 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Config and output bundle for clk_div_bank; master drives config, slave produces the waves.
// Pure wiring; config is a one-cycle strobe with no backpressure.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int DIV_W = DEF_DIV_W,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             sync;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_en, sync,
    input  clk_out, tick
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_en, sync,
    output clk_out, tick
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: pending/active ratio, period counter, registered wave and tick.
// Outputs registered (1 cycle after load); new ratios apply only at period end or sync, no stalls.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             en_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam int HALF_W = MAX_DIV_W + 1;

  logic [DIV_W-1:0]  div_p_q, div_p_d;
  logic              en_p_q, en_p_d;
  logic [DIV_W-1:0]  div_a_q, div_a_d;
  logic              en_a_q, en_a_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              clk_out_q, clk_out_d;
  logic              tick_q, tick_d;

  logic              running;
  logic              load;
  logic              next_running;
  logic [HALF_W-1:0] cnt_inc;
  logic [HALF_W-1:0] half_len;

  always_comb begin
    running      = en_a_q && (div_a_q != '0);
    // An idle channel reloads every edge so a fresh write starts on the next cycle.
    load         = sync_i || !running || (cnt_q == div_a_q);
    next_running = en_p_q && (div_p_q != '0);
    cnt_inc      = HALF_W'(cnt_q) + HALF_W'(1);
    half_len     = half(MAX_DIV_W'(div_a_q));

    div_p_d   = div_p_q;
    en_p_d    = en_p_q;
    div_a_d   = div_a_q;
    en_a_d    = en_a_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;

    if (wr_i) begin
      div_p_d = div_i;
      en_p_d  = en_i;
    end

    if (load) begin
      div_a_d   = div_p_q;
      en_a_d    = en_p_q;
      cnt_d     = '0;
      clk_out_d = next_running;
      tick_d    = next_running;
    end else begin
      cnt_d     = cnt_q + DIV_W'(1);
      tick_d    = 1'b0;
      clk_out_d = (cnt_inc < half_len);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_p_q   <= '0;
      en_p_q    <= 1'b0;
      div_a_q   <= '0;
      en_a_q    <= 1'b0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_p_q   <= div_p_d;
      en_p_q    <= en_p_d;
      div_a_q   <= div_a_d;
      en_a_q    <= en_a_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// N_CH-channel programmable clock-enable bank: decodes config writes, fans out sync.
// Write-to-output latency 2 edges on an idle channel; config is never stalled, bad channel ids drop.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int DIV_W = DEF_DIV_W
) (
  input logic             clk,
  input logic             rst_n,
  clk_div_bank_if.slave   bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] clk_out_w;
  logic [N_CH-1:0] tick_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;
    // Ids at or above N_CH match no channel, so those writes vanish.
    assign wr = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    clk_div_chan #(.DIV_W(DIV_W)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (wr),
      .div_i     (bus.cfg_div),
      .en_i      (bus.cfg_en),
      .sync_i    (bus.sync),
      .clk_out_o (clk_out_w[i]),
      .tick_o    (tick_w[i])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised and directed bench for clk_div_bank against a period/phase reference model.
module tb_clk_div_bank;

  localparam int N_CH  = 3;
  localparam int DIV_W = 8;
  localparam int CH_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  clk_div_bank_if #(.N_CH(N_CH), .DIV_W(DIV_W), .CH_W(CH_W)) bus();

  clk_div_bank #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending/active ratio per channel and the position within the current period.
  int div_p[N_CH], en_p[N_CH], div_a[N_CH], en_a[N_CH], pos[N_CH];

  function automatic bit m_run(int i);
    return (en_a[i] != 0) && (div_a[i] != 0);
  endfunction

  function automatic logic m_out(int i);
    int p;
    p = div_a[i] + 1;
    return logic'(m_run(i) && (pos[i] < (p + 1) / 2));
  endfunction

  function automatic logic m_tick(int i);
    return logic'(m_run(i) && (pos[i] == 0));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      div_p[i] = 0; en_p[i] = 0; div_a[i] = 0; en_a[i] = 0; pos[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < N_CH; i++) begin
      if (bus.sync || !m_run(i) || pos[i] == div_a[i] + 1 - 1) begin
        div_a[i] = div_p[i];
        en_a[i]  = en_p[i];
        pos[i]   = 0;
      end else begin
        pos[i]++;
      end
    end
    if (bus.cfg_we && int'(bus.cfg_ch) < N_CH) begin
      div_p[bus.cfg_ch] = int'(bus.cfg_div);
      en_p[bus.cfg_ch]  = int'(bus.cfg_en);
    end
    #1;
  endtask

  task automatic write(int ch, int div, bit en);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = CH_W'(ch);
    bus.cfg_div = DIV_W'(div);
    bus.cfg_en  = en;
    step();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clk_out !== '0 || bus.tick !== '0) begin
      errors++;
      $display("FAIL reset_hold: clk_out=%b tick=%b expected 000 000", bus.clk_out, bus.tick);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < N_CH; i++) begin
        checks++;
        if (bus.clk_out[i] !== m_out(i) || bus.tick[i] !== m_tick(i)) begin
          errors++;
          $display("FAIL reset_idle ch%0d: clk_out=%b tick=%b expected %b %b",
                   i, bus.clk_out[i], bus.tick[i], m_out(i), m_tick(i));
        end
      end
    end
  endtask

  task automatic test_div1();
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    write(0, 1, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.clk_out[0] !== pat[k] || bus.tick[0] !== pat[k]) begin
        errors++;
        $display("FAIL div1_pattern k=%0d: clk_out=%b tick=%b expected %b %b",
                 k, bus.clk_out[0], bus.tick[0], pat[k], pat[k]);
      end
      step();
    end
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        checks++;
        if (bus.clk_out[i] !== m_out(i) || bus.tick[i] !== m_tick(i)) begin
          errors++;
          $display("FAIL div1_model ch%0d: clk_out=%b tick=%b expected %b %b",
                   i, bus.clk_out[i], bus.tick[i], m_out(i), m_tick(i));
        end
      end
      step();
    end
  endtask

  task automatic test_div2_div255();
    int highs_a, highs_b, w;
    bit pat[3] = '{1'b1, 1'b1, 1'b0};
    write(1, 2, 1'b1);
    write(2, 255, 1'b1);
    for (int c = 0; c < 300; c++) begin
      step();
      for (int i = 0; i < N_CH; i++) begin
        checks++;
        if (bus.clk_out[i] !== m_out(i) || bus.tick[i] !== m_tick(i)) begin
          errors++;
          $display("FAIL div2_255_model ch%0d: clk_out=%b tick=%b expected %b %b",
                   i, bus.clk_out[i], bus.tick[i], m_out(i), m_tick(i));
        end
      end
    end
    w = 0;
    while (bus.tick[1] !== 1'b1 && w < 5) begin step(); w++; end
    checks++;
    if (w >= 5) begin
      errors++;
      $display("FAIL div2_tick_wait: tick[1] never rose within 5 cycles");
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.clk_out[1] !== pat[k]) begin
        errors++;
        $display("FAIL div2_pattern k=%0d: clk_out[1]=%b expected %b", k, bus.clk_out[1], pat[k]);
      end
      step();
    end
    w = 0;
    while (bus.tick[2] !== 1'b1 && w < 260) begin step(); w++; end
    checks++;
    if (w >= 260) begin
      errors++;
      $display("FAIL div255_tick_wait: tick[2] never rose within 260 cycles");
    end
    highs_a = 0;
    highs_b = 0;
    for (int k = 0; k < 256; k++) begin
      if (k < 128) highs_a += int'(bus.clk_out[2]);
      else         highs_b += int'(bus.clk_out[2]);
      step();
    end
    checks++;
    if (highs_a != 128 || highs_b != 0) begin
      errors++;
      $display("FAIL div255_duty: high cycles first/second half=%0d/%0d expected 128/0", highs_a, highs_b);
    end
  endtask

  task automatic test_ratio_change();
    int w;
    bit pat_chg[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit pat_dis[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    write(0, 3, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < N_CH; i++) begin
        checks++;
        if (bus.clk_out[i] !== m_out(i) || bus.tick[i] !== m_tick(i)) begin
          errors++;
          $display("FAIL ratio_model ch%0d: clk_out=%b tick=%b expected %b %b",
                   i, bus.clk_out[i], bus.tick[i], m_out(i), m_tick(i));
        end
      end
    end
    w = 0;
    while (bus.tick[0] !== 1'b1 && w < 8) begin step(); w++; end
    checks++;
    if (w >= 8) begin
      errors++;
      $display("FAIL ratio_tick_wait: tick[0] never rose within 8 cycles");
    end
    step();
    checks++;
    if (bus.clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL ratio_cnt1: clk_out[0]=%b expected 1", bus.clk_out[0]);
    end
    write(0, 5, 1'b1);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (bus.clk_out[0] !== pat_chg[k]) begin
        errors++;
        $display("FAIL ratio_change k=%0d: clk_out[0]=%b expected %b", k, bus.clk_out[0], pat_chg[k]);
      end
      step();
    end
    write(0, 5, 1'b0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (bus.clk_out[0] !== pat_dis[k] || bus.tick[0] !== m_tick(0)) begin
        errors++;
        $display("FAIL disable_mid k=%0d: clk_out[0]=%b tick[0]=%b expected %b %b",
                 k, bus.clk_out[0], bus.tick[0], pat_dis[k], m_tick(0));
      end
      step();
    end
  endtask

  task automatic test_sync();
    int w;
    write(0, 3, 1'b1);
    write(1, 5, 1'b1);
    for (int c = 0; c < 9; c++) step();
    w = 0;
    while (pos[0] == pos[1] && w < 6) begin step(); w++; end
    bus.sync    = 1'b1;
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = CH_W'(0);
    bus.cfg_div = DIV_W'(7);
    bus.cfg_en  = 1'b1;
    step();
    bus.sync   = 1'b0;
    bus.cfg_we = 1'b0;
    checks++;
    if (bus.tick[0] !== 1'b1 || bus.tick[1] !== 1'b1) begin
      errors++;
      $display("FAIL sync_tick: tick[1:0]=%b%b expected 11", bus.tick[1], bus.tick[0]);
    end
    for (int k = 1; k <= 13; k++) begin
      step();
      for (int i = 0; i < N_CH; i++) begin
        checks++;
        if (bus.clk_out[i] !== m_out(i) || bus.tick[i] !== m_tick(i)) begin
          errors++;
          $display("FAIL sync_model k=%0d ch%0d: clk_out=%b tick=%b expected %b %b",
                   k, i, bus.clk_out[i], bus.tick[i], m_out(i), m_tick(i));
        end
      end
      if (k == 4 || k == 12) begin
        checks++;
        if (bus.tick[0] !== 1'b1) begin
          errors++;
          $display("FAIL sync_deferred_write k=%0d: tick[0]=%b expected 1", k, bus.tick[0]);
        end
      end
    end
  endtask

  task automatic test_invalid();
    write(0, 0, 1'b0);
    write(1, 0, 1'b0);
    write(2, 0, 1'b0);
    for (int c = 0; c < 300; c++) step();
    write(3, 1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.clk_out !== '0 || bus.tick !== '0) begin
        errors++;
        $display("FAIL invalid_ch c=%0d: clk_out=%b tick=%b expected 000 000", c, bus.clk_out, bus.tick);
      end
      step();
    end
    write(1, 0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.clk_out[1] !== 1'b0 || bus.tick[1] !== 1'b0) begin
        errors++;
        $display("FAIL div0_off c=%0d: clk_out[1]=%b tick[1]=%b expected 0 0", c, bus.clk_out[1], bus.tick[1]);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      bus.cfg_we  = ($urandom_range(0, 7) == 0);
      bus.cfg_ch  = CH_W'($urandom_range(0, 3));
      bus.cfg_div = ($urandom_range(0, 15) == 0) ? DIV_W'(255) : DIV_W'($urandom_range(0, 9));
      bus.cfg_en  = ($urandom_range(0, 4) != 0);
      bus.sync    = ($urandom_range(0, 39) == 0);
      step();
      for (int i = 0; i < N_CH; i++) begin
        checks++;
        if (bus.clk_out[i] !== m_out(i) || bus.tick[i] !== m_tick(i)) begin
          errors++;
          $display("FAIL random c=%0d ch%0d: clk_out=%b tick=%b expected %b %b",
                   c, i, bus.clk_out[i], bus.tick[i], m_out(i), m_tick(i));
        end
      end
    end
    bus.cfg_we = 1'b0;
    bus.sync   = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    write(0, 3, 1'b1);
    w = 0;
    while (bus.clk_out[0] !== 1'b1 && w < 12) begin step(); w++; end
    checks++;
    if (w >= 12) begin
      errors++;
      $display("FAIL reset_mid_wait: clk_out[0] never high within 12 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clk_out !== '0 || bus.tick !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: clk_out=%b tick=%b expected 000 000", bus.clk_out, bus.tick);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.clk_out !== '0 || bus.tick !== '0) begin
        errors++;
        $display("FAIL reset_mid_idle c=%0d: clk_out=%b tick=%b expected 000 000", c, bus.clk_out, bus.tick);
      end
    end
  endtask

  initial begin
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_div = '0;
    bus.cfg_en  = 1'b0;
    bus.sync    = 1'b0;
    test_reset();
    test_div1();
    test_div2_div255();
    test_ratio_change();
    test_sync();
    test_invalid();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
